trigger_sequencer: RTL
======================

# trigger_sequencer

Table-driven scheduler for a bank of `NUM_CH` trigger/LED output channels. It stores up to `DEPTH` steps, each with a channel mask, delay and duration. On `start` it arms the masked channels with the mark/go handshake, waits for all of them to complete, clears them, and advances through the table for a programmable number of loops. It sits between the host register interface and the per-channel trigger output blocks, and forwards `hardStop` to every channel.

## Interface
- `NUM_CH`, 4, number of trigger/LED output channels driven
- `DEPTH`, 16, step table entries; `AW = clog2(DEPTH)`
- `clk  in  1`  system clock
- `rst  in  1`  synchronous, active-high reset
- `cfg_we  in  1`  table write strobe; ignored while `busy`
- `cfg_addr  in  AW`  table write address
- `cfg_mask  in  NUM_CH`  step channel mask; 0 = pure wait step
- `cfg_delay  in  21`  step delay in clk cycles
- `cfg_dur  in  11`  step active duration in clk cycles
- `num_steps  in  AW+1`  steps per loop, 0..DEPTH; sampled at `start`
- `num_loops  in  16`  loop count; 0 = run until `hardStop`; sampled at `start`
- `start  in  1`  one-cycle start pulse; honoured only in IDLE
- `hardStop  in  1`  immediate abort
- `ch_mark  out  NUM_CH`  per-channel onYourMark
- `ch_go  out  NUM_CH`  per-channel GO
- `ch_rst  out  NUM_CH`  per-channel reset, active-high
- `ch_hardStop  out  1`  registered copy of `hardStop`
- `ch_delay  out  21`  shared delay bus to channels
- `ch_dur  out  11`  shared duration bus to channels
- `ch_complete  in  NUM_CH`  per-channel completion flags
- `busy  out  1`  high from the cycle after an accepted `start` until the sequence returns to IDLE
- `done  out  1`  one-cycle pulse on normal completion
- `aborted  out  1`  sticky; set by `hardStop`; cleared by the next accepted `start` or by `rst`
- `step_idx  out  AW`  current step
- `loop_cnt  out  16`  loops completed

## Operation
- Table: `DEPTH` × (`NUM_CH` + 32) registers. Write-only from the host. Reads are registered, 1-cycle latency.
- States:
  - IDLE: outputs quiet. `start` with `num_steps` ≠ 0 → LOAD, with `step_idx` = 0, `loop_cnt` = 0 and `aborted` cleared. `start` with `num_steps` = 0 → pulse `done`, stay in IDLE.
  - LOAD (1 cycle): present `step_idx` to the table.
  - MARK (2 cycles): latch the entry and drive `ch_delay`/`ch_dur`. `ch_mark` = mask, `ch_go` = 0. If mask = 0, go to DWELL instead.
  - GO: `ch_mark` = `ch_go` = mask, held. Enter a 2-cycle guard in which `ch_complete` is ignored. After the guard, move to CLEAR when `(ch_complete & mask) == mask`.
  - DWELL (mask = 0 only): count `delay + dur` cycles using a 22-bit sum. Then → NEXT. A zero sum spends 1 cycle here.
  - CLEAR (1 cycle): `ch_mark` = `ch_go` = 0, `ch_rst` = mask.
  - NEXT (1 cycle): `step_idx`+1.
    - If it reaches `num_steps`: `step_idx` ← 0 and `loop_cnt`+1 (saturating at 0xFFFF). If `num_loops` ≠ 0 and the new `loop_cnt` equals `num_loops` → IDLE and pulse `done`; otherwise → LOAD.
    - Otherwise → LOAD.
- `ch_delay`/`ch_dur` are held constant from the first MARK cycle through CLEAR.
- Unmasked channels: `ch_mark`, `ch_go` and `ch_rst` stay 0 throughout the step.
- `hardStop` (any state):
  - Next cycle: `ch_hardStop` = 1; `ch_mark`, `ch_go`, `ch_rst` = 0; state → IDLE; `aborted` = 1; `busy` = 0.
  - `start` is ignored while `hardStop` is high.
- `rst` (any state, including mid-sequence):
  - Next cycle: all outputs take their reset values and the state is IDLE.
  - `ch_rst` is driven all-ones for that single cycle.
  - Table contents are not cleared.
- `cfg_we` during `busy` is dropped with no effect.

## Timing
- Reset values: `ch_mark` = `ch_go` = 0, `ch_rst` = all-ones (1 cycle, then 0), `ch_hardStop` = 0, `ch_delay` = `ch_dur` = 0, `busy` = `done` = `aborted` = 0, `step_idx` = 0, `loop_cnt` = 0.
- `start` at edge T: `busy` = 1 at T+1 (LOAD). MARK during T+2..T+3. `ch_go` first high at T+4.
- Channel output active window: begins `delay` + ~2 cycles after `ch_go` rises and lasts `dur` cycles. The sequencer does not time this window; it only waits for `ch_complete`.
- Per-step overhead excluding channel time: LOAD 1 + MARK 2 + guard 2 + CLEAR 1 + NEXT 1 = 7 cycles.
- `done` is asserted in the same cycle that `busy` falls.

## Test plan
- Single step, mask=4'b0001, delay=10, dur=5, `num_steps`=1, `num_loops`=1 → ch0 output high for 5 cycles; `ch_rst`[0] pulses once; `done` pulses once; `loop_cnt`=1; ch1–3 stay idle.
- Three steps with masks 0011 / 0000 (delay=20, dur=0) / 1000, `num_loops`=2 → issue order 0011, 20-cycle dwell, 1000, then repeat; exactly 4 channel `ch_rst` pulses; `loop_cnt`=2.
- Model channel 1 completing 50 cycles after channel 0 with mask=0011 → CLEAR entered only after the ch1 completion; `ch_go` held until then.
- `hardStop` during GO with `num_loops`=0 → next cycle `ch_go`=0, `busy`=0, `aborted`=1, no `done`; a following `start` clears `aborted` and restarts at step 0.
- `start` with `num_steps`=0 → `done` pulses at T+1 and `busy` never rises. `cfg_we` while `busy` → table readback unchanged.
- `rst` asserted mid-DWELL → next cycle all outputs at reset values with `ch_rst`=1111 for one cycle; table contents preserved, so a rerun gives an identical sequence.

Source files
------------

// File: rtl/trigger_sequencer_if.sv
// rtl/trigger_sequencer_if.sv - sequencer-to-channel trigger bus
//
// Bundles everything the sequencer exchanges with the bank of per-channel
// trigger/LED output blocks.
//   ch_mark     per-channel onYourMark
//   ch_go       per-channel GO
//   ch_rst      per-channel reset, active-high
//   ch_hardStop registered abort broadcast to all channels
//   ch_delay    shared delay bus (clk cycles)
//   ch_dur      shared active-duration bus (clk cycles)
//   ch_complete per-channel completion flags, driven by the channels
// master: sequencer side. slave: channel-bank side.

interface trigger_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] ch_mark;
    logic [NUM_CH-1:0] ch_go;
    logic [NUM_CH-1:0] ch_rst;
    logic              ch_hardStop;
    logic [20:0]       ch_delay;
    logic [10:0]       ch_dur;
    logic [NUM_CH-1:0] ch_complete;

    modport master (
        output ch_mark, ch_go, ch_rst, ch_hardStop, ch_delay, ch_dur,
        input  ch_complete
    );

    modport slave (
        input  ch_mark, ch_go, ch_rst, ch_hardStop, ch_delay, ch_dur,
        output ch_complete
    );
endinterface

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - table-driven trigger/LED channel scheduler
//
// Steps through a host-written table of {mask, delay, dur} entries. Each
// masked step arms its channels (mark, then mark+go), waits until every
// masked channel reports complete, pulses their resets and advances. Steps
// with an empty mask are pure waits of delay+dur cycles. The table is
// replayed num_loops times (0 = until hardStop).
//   clk, rst               clock, synchronous active-high reset
//   cfg_we/addr/mask/delay/dur   table write port (dropped while busy)
//   num_steps, num_loops, start  run control, sampled on an accepted start
//   hardStop               immediate abort
//   chan                   channel bus (master side)
//   busy, done, aborted    run status
//   step_idx, loop_cnt     progress

module trigger_sequencer #(
    parameter  int NUM_CH = 4,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [NUM_CH-1:0]    cfg_mask,
    input  logic [20:0]          cfg_delay,
    input  logic [10:0]          cfg_dur,
    input  logic [AW:0]          num_steps,
    input  logic [15:0]          num_loops,
    input  logic                 start,
    input  logic                 hardStop,
    trigger_sequencer_if.master  chan,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [AW-1:0]        step_idx,
    output logic [15:0]          loop_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MARK, S_GO, S_DWELL, S_CLEAR, S_NEXT
    } state_t;

    state_t state;

    logic [NUM_CH-1:0] mask_mem  [DEPTH];
    logic [20:0]       delay_mem [DEPTH];
    logic [10:0]       dur_mem   [DEPTH];

    logic [NUM_CH-1:0] mark_q, go_q, chrst_q, mask_q;
    logic              hs_q;
    logic [20:0]       delay_q;
    logic [10:0]       dur_q;
    logic [21:0]       cnt;
    logic [AW:0]       nsteps_q;
    logic [15:0]       nloops_q;

    logic [AW:0]       step_inc;
    logic [15:0]       loop_inc;

    assign step_inc = {1'b0, step_idx} + 1'b1;
    assign loop_inc = (loop_cnt == 16'hFFFF) ? loop_cnt : loop_cnt + 16'd1;

    assign chan.ch_mark     = mark_q;
    assign chan.ch_go       = go_q;
    assign chan.ch_rst      = chrst_q;
    assign chan.ch_hardStop = hs_q;
    assign chan.ch_delay    = delay_q;
    assign chan.ch_dur      = dur_q;

    // Table storage is deliberately not reset so a run can be repeated after rst.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            mask_mem[cfg_addr]  <= cfg_mask;
            delay_mem[cfg_addr] <= cfg_delay;
            dur_mem[cfg_addr]   <= cfg_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mark_q   <= '0;
            go_q     <= '0;
            chrst_q  <= '1;
            mask_q   <= '0;
            hs_q     <= 1'b0;
            delay_q  <= '0;
            dur_q    <= '0;
            cnt      <= '0;
            nsteps_q <= '0;
            nloops_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            step_idx <= '0;
            loop_cnt <= '0;
        end else begin
            hs_q    <= hardStop;
            done    <= 1'b0;
            chrst_q <= '0;
            if (hardStop) begin
                state   <= S_IDLE;
                mark_q  <= '0;
                go_q    <= '0;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (num_steps == '0) begin
                                done <= 1'b1;
                            end else begin
                                state    <= S_LOAD;
                                busy     <= 1'b1;
                                aborted  <= 1'b0;
                                step_idx <= '0;
                                loop_cnt <= '0;
                                nsteps_q <= num_steps;
                                nloops_q <= num_loops;
                            end
                        end
                    end
                    // The registered table read lands directly in the output
                    // latches, so mark and the shared buses appear on the
                    // first MARK cycle.
                    S_LOAD: begin
                        state   <= S_MARK;
                        mask_q  <= mask_mem[step_idx];
                        mark_q  <= mask_mem[step_idx];
                        delay_q <= delay_mem[step_idx];
                        dur_q   <= dur_mem[step_idx];
                        cnt     <= 22'd1;
                    end
                    S_MARK: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 22'd1;
                        end else if (mask_q == '0) begin
                            state <= S_DWELL;
                            cnt   <= {1'b0, delay_q} + {11'd0, dur_q};
                        end else begin
                            state <= S_GO;
                            go_q  <= mask_q;
                            cnt   <= 22'd2;
                        end
                    end
                    // Two guard cycles let channels drop stale completion
                    // flags before they are trusted.
                    S_GO: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 22'd1;
                        end else if ((chan.ch_complete & mask_q) == mask_q) begin
                            state   <= S_CLEAR;
                            mark_q  <= '0;
                            go_q    <= '0;
                            chrst_q <= mask_q;
                        end
                    end
                    // A zero or one cycle dwell both leave after one cycle.
                    S_DWELL: begin
                        if (cnt > 22'd1) cnt <= cnt - 22'd1;
                        else             state <= S_NEXT;
                    end
                    S_CLEAR: begin
                        state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (step_inc == nsteps_q) begin
                            step_idx <= '0;
                            loop_cnt <= loop_inc;
                            if (nloops_q != '0 && loop_inc == nloops_q) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                            end
                        end else begin
                            step_idx <= step_inc[AW-1:0];
                            state    <= S_LOAD;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
